// File: rtl/pcie_ss_axis_tx_merge.sv
// pcie_ss_axis_tx_merge
//   Merges two host-bound TX AXI-S streams (A, B) into one PCIe SS TX stream.
//   Arbitration is packet-atomic round-robin; a 2-entry skid buffer sits on
//   the output so no input tready depends combinationally on tx_tready.
//   Optional feature macro: PCIE_SS_TX_MERGE_STATS_EN (per-input packet counters).
//
//   Handshake: a beat transfers on any channel exactly in a cycle where
//   tvalid && tready are both high at the rising clock edge. A source holds
//   tvalid and its payload stable until the transfer happens. tready may be
//   asserted independently of tvalid.
module pcie_ss_axis_tx_merge #(
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tx_a_tvalid,
  output logic                    tx_a_tready,
  input  logic [DATA_WIDTH-1:0]   tx_a_tdata,
  input  logic [DATA_WIDTH/8-1:0] tx_a_tkeep,
  input  logic                    tx_a_tlast,
  input  logic [USER_WIDTH-1:0]   tx_a_tuser_vendor,
  input  logic                    tx_b_tvalid,
  output logic                    tx_b_tready,
  input  logic [DATA_WIDTH-1:0]   tx_b_tdata,
  input  logic [DATA_WIDTH/8-1:0] tx_b_tkeep,
  input  logic                    tx_b_tlast,
  input  logic [USER_WIDTH-1:0]   tx_b_tuser_vendor,
  output logic                    tx_tvalid,
  input  logic                    tx_tready,
  output logic [DATA_WIDTH-1:0]   tx_tdata,
  output logic [DATA_WIDTH/8-1:0] tx_tkeep,
  output logic                    tx_tlast,
  output logic [USER_WIDTH-1:0]   tx_tuser_vendor,
  output logic [31:0]             pkt_cnt_a,
  output logic [31:0]             pkt_cnt_b,
  output logic [1:0]              dbg_state_o
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;   // 0 = A, 1 = B
  logic   space_q, space_d;
  logic [1:0] count_q, count_d;
  logic   rd_ptr_q, rd_ptr_d;
  logic   wr_ptr_q, wr_ptr_d;

  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [KEEP_WIDTH-1:0] buf_keep_q [2];
  logic                  buf_last_q [2];
  logic [USER_WIDTH-1:0] buf_user_q [2];

  logic grant_a, grant_b, push, pop;
  logic in_last;
  logic [DATA_WIDTH-1:0] in_data;
  logic [KEEP_WIDTH-1:0] in_keep;
  logic [USER_WIDTH-1:0] in_user;

  // Arbitration, input readies and FSM next state
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    tx_a_tready  = 1'b0;
    tx_b_tready  = 1'b0;
    push         = 1'b0;
    in_last      = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_a_tvalid && tx_b_tvalid) begin
          // Contention: the input that did not win last time goes now.
          grant_a = last_grant_q;
          grant_b = !last_grant_q;
        end else begin
          grant_a = tx_a_tvalid;
          grant_b = tx_b_tvalid;
        end
      end
      LOCK_A:  grant_a = 1'b1;
      LOCK_B:  grant_b = 1'b1;
      default: state_d = IDLE;
    endcase
    tx_a_tready = space_q && grant_a;
    tx_b_tready = space_q && grant_b;
    push        = (tx_a_tready && tx_a_tvalid) || (tx_b_tready && tx_b_tvalid);
    in_last     = grant_b ? tx_b_tlast : tx_a_tlast;
    if (push) begin
      if (state_q == IDLE) last_grant_d = grant_b;
      if (in_last) state_d = IDLE;
      else         state_d = grant_b ? LOCK_B : LOCK_A;
    end
  end

  // Payload of the granted input
  always_comb begin
    in_data = grant_b ? tx_b_tdata        : tx_a_tdata;
    in_keep = grant_b ? tx_b_tkeep        : tx_a_tkeep;
    in_user = grant_b ? tx_b_tuser_vendor : tx_a_tuser_vendor;
  end

  assign tx_tvalid = (count_q != 2'd0);
  assign pop       = tx_tvalid && tx_tready;

  // Skid buffer pointer/occupancy next state; space is registered from it
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    space_d = (count_d != 2'd2);
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      space_q      <= 1'b0;
      count_q      <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      space_q      <= space_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  // Skid buffer storage; payload needs no reset since count qualifies it
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data_q[wr_ptr_q] <= in_data;
      buf_keep_q[wr_ptr_q] <= in_keep;
      buf_last_q[wr_ptr_q] <= in_last;
      buf_user_q[wr_ptr_q] <= in_user;
    end
  end

  assign tx_tdata        = buf_data_q[rd_ptr_q];
  assign tx_tkeep        = buf_keep_q[rd_ptr_q];
  assign tx_tlast        = buf_last_q[rd_ptr_q];
  assign tx_tuser_vendor = buf_user_q[rd_ptr_q];
  assign dbg_state_o     = state_q;

`ifdef PCIE_SS_TX_MERGE_STATS_EN
  logic        buf_src_q [2];
  logic [31:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

  // Source tag travels with each buffered beat
  always_ff @(posedge clk) begin
    if (push) buf_src_q[wr_ptr_q] <= grant_b;
  end

  // Count packets as their last beat leaves on the merged stream; wraps
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (pop && tx_tlast) begin
      if (buf_src_q[rd_ptr_q]) cnt_b_d = cnt_b_q + 32'd1;
      else                     cnt_a_d = cnt_a_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_q <= 32'd0;
      cnt_b_q <= 32'd0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign pkt_cnt_a = cnt_a_q;
  assign pkt_cnt_b = cnt_b_q;
`else
  assign pkt_cnt_a = 32'd0;
  assign pkt_cnt_b = 32'd0;
`endif

endmodule

// File: tb/tb_pcie_ss_axis_tx_merge.sv
// Bench for pcie_ss_axis_tx_merge. Each beat carries a 33-bit tag
// {tlast, src, seq[30:0]} replicated across tdata; tkeep and tuser are
// derived from the same tag so payload integrity is checked per beat.
`timescale 1ns/1ps
module tb_pcie_ss_axis_tx_merge;
  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int UW = 10;
`ifdef PCIE_SS_TX_MERGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx_a_tvalid, tx_a_tready, tx_a_tlast;
  logic [DW-1:0] tx_a_tdata;
  logic [KW-1:0] tx_a_tkeep;
  logic [UW-1:0] tx_a_tuser_vendor;
  logic          tx_b_tvalid, tx_b_tready, tx_b_tlast;
  logic [DW-1:0] tx_b_tdata;
  logic [KW-1:0] tx_b_tkeep;
  logic [UW-1:0] tx_b_tuser_vendor;
  logic          tx_tvalid, tx_tready, tx_tlast;
  logic [DW-1:0] tx_tdata;
  logic [KW-1:0] tx_tkeep;
  logic [UW-1:0] tx_tuser_vendor;
  logic [31:0]   pkt_cnt_a, pkt_cnt_b;
  logic [1:0]    dbg_state_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int seq_a = 0;
  int seq_b = 0;
  int acc_a_n = 0;
  int acc_b_n = 0;
  int integ_bad = 0;
  int ready_mode = 0;      // 0: tready low, 1: tready high, 2: random
  bit force_valid = 1'b0;  // drive tvalid with dummy data while queues empty

  logic [32:0] a_q[$], b_q[$];
  logic [32:0] exp_a_q[$], exp_b_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] out_q[$];
  int          out_cyc_q[$];
  int          acc_a_cyc_q[$];

  pcie_ss_axis_tx_merge #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk(clk), .rst(rst),
    .tx_a_tvalid(tx_a_tvalid), .tx_a_tready(tx_a_tready), .tx_a_tdata(tx_a_tdata),
    .tx_a_tkeep(tx_a_tkeep), .tx_a_tlast(tx_a_tlast), .tx_a_tuser_vendor(tx_a_tuser_vendor),
    .tx_b_tvalid(tx_b_tvalid), .tx_b_tready(tx_b_tready), .tx_b_tdata(tx_b_tdata),
    .tx_b_tkeep(tx_b_tkeep), .tx_b_tlast(tx_b_tlast), .tx_b_tuser_vendor(tx_b_tuser_vendor),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
    .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast), .tx_tuser_vendor(tx_tuser_vendor),
    .pkt_cnt_a(pkt_cnt_a), .pkt_cnt_b(pkt_cnt_b), .dbg_state_o(dbg_state_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Drivers and monitor: sample handshakes at negedge, update inputs #1 after posedge
  initial begin : driver
    logic fire_a, fire_b, fire_o;
    logic [32:0] w;
    tx_a_tvalid = 1'b0; tx_a_tdata = '0; tx_a_tkeep = '0; tx_a_tlast = 1'b0; tx_a_tuser_vendor = '0;
    tx_b_tvalid = 1'b0; tx_b_tdata = '0; tx_b_tkeep = '0; tx_b_tlast = 1'b0; tx_b_tuser_vendor = '0;
    tx_tready = 1'b0;
    forever begin
      @(negedge clk);
      fire_a = tx_a_tvalid && tx_a_tready;
      fire_b = tx_b_tvalid && tx_b_tready;
      fire_o = tx_tvalid && tx_tready;
      if (fire_a) begin
        acc_a_n++;
        acc_a_cyc_q.push_back(cyc);
      end
      if (fire_b) acc_b_n++;
      if (fire_o) begin
        out_q.push_back({tx_tlast, tx_tdata[31:0]});
        out_cyc_q.push_back(cyc);
        if (tx_tdata !== {16{tx_tdata[31:0]}} || tx_tkeep !== {2{tx_tdata[31:0]}} ||
            tx_tuser_vendor !== tx_tdata[9:0])
          integ_bad++;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (fire_a && a_q.size() > 0) w = a_q.pop_front();
      if (fire_b && b_q.size() > 0) w = b_q.pop_front();
      if (a_q.size() > 0) begin
        w = a_q[0];
        tx_a_tvalid = 1'b1; tx_a_tdata = {16{w[31:0]}}; tx_a_tkeep = {2{w[31:0]}};
        tx_a_tlast = w[32]; tx_a_tuser_vendor = w[9:0];
      end else begin
        tx_a_tvalid = force_valid; tx_a_tdata = '0; tx_a_tkeep = '0;
        tx_a_tlast = 1'b1; tx_a_tuser_vendor = '0;
      end
      if (b_q.size() > 0) begin
        w = b_q[0];
        tx_b_tvalid = 1'b1; tx_b_tdata = {16{w[31:0]}}; tx_b_tkeep = {2{w[31:0]}};
        tx_b_tlast = w[32]; tx_b_tuser_vendor = w[9:0];
      end else begin
        tx_b_tvalid = force_valid; tx_b_tdata = '0; tx_b_tkeep = '0;
        tx_b_tlast = 1'b1; tx_b_tuser_vendor = '0;
      end
      if (ready_mode == 2) tx_tready = 1'($urandom_range(0, 1));
      else                 tx_tready = (ready_mode == 1);
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    a_q.delete(); b_q.delete(); exp_a_q.delete(); exp_b_q.delete(); exp_q.delete();
    repeat (n) @(negedge clk);
    out_q.delete(); out_cyc_q.delete(); acc_a_cyc_q.delete();
    acc_a_n = 0; acc_b_n = 0; integ_bad = 0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic load_pkt(input bit src, input int n);
    for (int i = 0; i < n; i++) begin
      logic [32:0] w;
      if (!src) begin
        w = {(i == n - 1), 1'b0, 31'(seq_a)};
        seq_a++;
        a_q.push_back(w);
        exp_a_q.push_back(w);
      end else begin
        w = {(i == n - 1), 1'b1, 31'(seq_b)};
        seq_b++;
        b_q.push_back(w);
        exp_b_q.push_back(w);
      end
    end
  endtask

  task automatic wait_out(input int n, input int limit);
    int k = 0;
    while (out_q.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    force_valid = 1'b1;
    ready_mode = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (tx_a_tready !== 1'b0 || tx_b_tready !== 1'b0) begin
        errors++;
        $display("FAIL reset_tready: a=%b b=%b expected 0 0", tx_a_tready, tx_b_tready);
      end
      checks++;
      if (tx_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL reset_tvalid: got %b expected 0", tx_tvalid);
      end
      checks++;
      if (pkt_cnt_a !== 32'd0 || pkt_cnt_b !== 32'd0) begin
        errors++;
        $display("FAIL reset_counters: a=%0d b=%0d expected 0 0", pkt_cnt_a, pkt_cnt_b);
      end
      checks++;
      if (dbg_state_o !== 2'd0) begin
        errors++;
        $display("FAIL reset_state: got %0d expected 0 (IDLE)", dbg_state_o);
      end
    end
    force_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_contention;
    int base_a, base_b, n;
    apply_reset(2);
    ready_mode = 1;
    base_a = seq_a;
    base_b = seq_b;
    load_pkt(1'b0, 3);
    load_pkt(1'b1, 3);
    for (int i = 0; i < 3; i++) exp_q.push_back({(i == 2), 1'b0, 31'(base_a + i)});
    for (int i = 0; i < 3; i++) exp_q.push_back({(i == 2), 1'b1, 31'(base_b + i)});
    wait_out(6, 60);
    repeat (4) @(negedge clk);
    checks++;
    if (out_q.size() !== 6) begin
      errors++;
      $display("FAIL contention_count: got %0d beats expected 6", out_q.size());
    end
    n = (out_q.size() < 6) ? out_q.size() : 6;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL contention_beat%0d: got %h expected %h", i, out_q[i], exp_q[i]);
      end
      if (i > 0) begin
        checks++;
        if (out_cyc_q[i] !== out_cyc_q[0] + i) begin
          errors++;
          $display("FAIL contention_gap%0d: cycle %0d expected %0d", i, out_cyc_q[i], out_cyc_q[0] + i);
        end
      end
    end
    if (n > 0 && acc_a_cyc_q.size() > 0) begin
      checks++;
      if (out_cyc_q[0] !== acc_a_cyc_q[0] + 1) begin
        errors++;
        $display("FAIL contention_latency: first out cycle %0d expected %0d", out_cyc_q[0], acc_a_cyc_q[0] + 1);
      end
    end
  endtask

  task automatic test_fairness;
    int base_a, base_b, n;
    apply_reset(2);
    ready_mode = 1;
    base_a = seq_a;
    base_b = seq_b;
    for (int i = 0; i < 4; i++) begin
      load_pkt(1'b0, 1);
      load_pkt(1'b1, 1);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b1, 1'b0, 31'(base_a + i)});
      exp_q.push_back({1'b1, 1'b1, 31'(base_b + i)});
    end
    wait_out(8, 60);
    repeat (4) @(negedge clk);
    checks++;
    if (out_q.size() !== 8) begin
      errors++;
      $display("FAIL fairness_count: got %0d beats expected 8", out_q.size());
    end
    n = (out_q.size() < 8) ? out_q.size() : 8;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL fairness_grant%0d: got %h expected %h", i, out_q[i], exp_q[i]);
      end
      if (i > 0) begin
        checks++;
        if (out_cyc_q[i] !== out_cyc_q[0] + i) begin
          errors++;
          $display("FAIL fairness_gap%0d: cycle %0d expected %0d", i, out_cyc_q[i], out_cyc_q[0] + i);
        end
      end
    end
  endtask

  task automatic test_stall;
    int base_a, base_b, n;
    apply_reset(2);
    ready_mode = 1;
    base_a = seq_a;
    base_b = seq_b;
    load_pkt(1'b0, 8);
    load_pkt(1'b1, 2);
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 1'b0, 31'(base_a + i)});
    for (int i = 0; i < 2; i++) exp_q.push_back({(i == 1), 1'b1, 31'(base_b + i)});
    wait_out(3, 40);
    ready_mode = 0;
    repeat (10) @(negedge clk);
    checks++;
    if (acc_a_n - out_q.size() !== 2) begin
      errors++;
      $display("FAIL stall_buffered: got %0d beats held expected 2", acc_a_n - out_q.size());
    end
    checks++;
    if (tx_a_tready !== 1'b0 || tx_b_tready !== 1'b0) begin
      errors++;
      $display("FAIL stall_tready: a=%b b=%b expected 0 0", tx_a_tready, tx_b_tready);
    end
    checks++;
    if (tx_tvalid !== 1'b1 || {tx_tlast, tx_tdata[31:0]} !== exp_q[out_q.size()]) begin
      errors++;
      $display("FAIL stall_head: valid=%b beat=%h expected 1 %h", tx_tvalid, {tx_tlast, tx_tdata[31:0]},
               exp_q[out_q.size()]);
    end
    checks++;
    if (dbg_state_o !== 2'd1) begin
      errors++;
      $display("FAIL stall_state: got %0d expected 1 (LOCK_A)", dbg_state_o);
    end
    ready_mode = 1;
    wait_out(10, 60);
    repeat (4) @(negedge clk);
    checks++;
    if (out_q.size() !== 10) begin
      errors++;
      $display("FAIL stall_count: got %0d beats expected 10", out_q.size());
    end
    n = (out_q.size() < 10) ? out_q.size() : 10;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stall_beat%0d: got %h expected %h", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int total = 0;
    int len;
    bit in_pkt = 1'b0;
    bit cur_src = 1'b0;
    logic [32:0] w, e;
    apply_reset(2);
    ready_mode = 2;
    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(1, 8);
      load_pkt(1'b0, len);
      total += len;
      len = $urandom_range(1, 8);
      load_pkt(1'b1, len);
      total += len;
    end
    wait_out(total, 20000);
    ready_mode = 1;
    repeat (5) @(negedge clk);
    checks++;
    if (out_q.size() !== total) begin
      errors++;
      $display("FAIL bp_count: got %0d beats expected %0d", out_q.size(), total);
    end
    for (int i = 0; i < out_q.size(); i++) begin
      w = out_q[i];
      if (in_pkt) begin
        checks++;
        if (w[31] !== cur_src) begin
          errors++;
          $display("FAIL bp_interleave: beat %0d src %b inside packet from %b", i, w[31], cur_src);
        end
      end
      if (w[31]) e = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 33'h0;
      else       e = (exp_a_q.size() > 0) ? exp_a_q.pop_front() : 33'h0;
      checks++;
      if (w !== e) begin
        errors++;
        $display("FAIL bp_order: beat %0d got %h expected %h", i, w, e);
      end
      in_pkt = !w[32];
      cur_src = w[31];
    end
    checks++;
    if (exp_a_q.size() !== 0 || exp_b_q.size() !== 0) begin
      errors++;
      $display("FAIL bp_loss: undelivered a=%0d b=%0d expected 0 0", exp_a_q.size(), exp_b_q.size());
    end
    checks++;
    if (integ_bad !== 0) begin
      errors++;
      $display("FAIL bp_payload: %0d beats with corrupt tdata/tkeep/tuser, expected 0", integ_bad);
    end
    checks++;
    if (pkt_cnt_a !== (STATS ? 32'd100 : 32'd0) || pkt_cnt_b !== (STATS ? 32'd100 : 32'd0)) begin
      errors++;
      $display("FAIL bp_counters: a=%0d b=%0d expected %0d", pkt_cnt_a, pkt_cnt_b, STATS ? 100 : 0);
    end
  endtask

  task automatic test_stats;
    apply_reset(2);
    ready_mode = 1;
    load_pkt(1'b0, 1); load_pkt(1'b0, 2); load_pkt(1'b0, 3); load_pkt(1'b0, 1); load_pkt(1'b0, 2);
    load_pkt(1'b1, 2); load_pkt(1'b1, 1); load_pkt(1'b1, 3);
    wait_out(15, 100);
    repeat (4) @(negedge clk);
    checks++;
    if (out_q.size() !== 15) begin
      errors++;
      $display("FAIL stats_beats: got %0d expected 15", out_q.size());
    end
    checks++;
    if (pkt_cnt_a !== (STATS ? 32'd5 : 32'd0)) begin
      errors++;
      $display("FAIL stats_cnt_a: got %0d expected %0d", pkt_cnt_a, STATS ? 5 : 0);
    end
    checks++;
    if (pkt_cnt_b !== (STATS ? 32'd3 : 32'd0)) begin
      errors++;
      $display("FAIL stats_cnt_b: got %0d expected %0d", pkt_cnt_b, STATS ? 3 : 0);
    end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_contention();
    test_fairness();
    test_stall();
    test_backpressure();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
